// File: rtl/sid_arb_pkg.sv
// Shared types and constants for the dual-SID register bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: state enum, port ids, minimum bus timing, request bundle, max helper.
package sid_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        RECOVER
    } arb_state_e;

    localparam logic PORT_HOST   = 1'b0;
    localparam logic PORT_PLAYER = 1'b1;

    // The SID registers CEb/RWb, so a strobe shorter than two cycles or no
    // recovery cycle would let it miss or merge accesses.
    localparam int MIN_STROBE  = 2;
    localparam int MIN_RECOVER = 1;

    typedef struct packed {
        logic       we;
        logic [5:0] addr;
        logic [7:0] wdata;
    } acc_req_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sid_arb_rr.sv
// Two-way round-robin picker: the port that was not granted last wins a tie.
// Latency: combinational.
// Backpressure: none; the caller only acts on the grant when it is free to.
// Ports: req[1:0] requests (bit index = port id), last = previous grant,
//        gnt_vld = any request, gnt_id = chosen port.
module sid_arb_rr
    import sid_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_vld,
    output logic       gnt_id
);

    always_comb begin
        gnt_vld = |req;
        gnt_id  = PORT_HOST;
        if (req[PORT_HOST] && req[PORT_PLAYER]) begin
            gnt_id = ~last;
        end else if (req[PORT_PLAYER]) begin
            gnt_id = PORT_PLAYER;
        end
    end

endmodule

// File: rtl/sid_bus_arbiter.sv
// Shares the SID register bus between the host CPU (port 0) and the register-stream player (port 1).
// Latency: request seen in IDLE -> ack after 2 + STROBE_CYC + RECOVER_CYC cycles (5 at defaults).
// Backpressure: a requester holds req and its fields until its one-cycle ack; the loser of a tie waits.
// Ports: h_* host port, p_* player port (req/we/addr/wdata in, ack/rdata out);
//        sid_ceb/sid_rwb/sid_addr/sid_wdata drive sid_top, sid_rdata comes back from it;
//        busy = access in progress, gnt_id = owner of current/last access.
// Option: define SID_ARB_FRAME_SYNC_EN to add frame_tick/p_eof and gate the player per frame.
module sid_bus_arbiter
    import sid_arb_pkg::*;
#(
    parameter int STROBE_CYC  = 2,
    parameter int RECOVER_CYC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       h_req,
    input  logic       h_we,
    input  logic [5:0] h_addr,
    input  logic [7:0] h_wdata,
    output logic       h_ack,
    output logic [7:0] h_rdata,
    input  logic       p_req,
    input  logic       p_we,
    input  logic [5:0] p_addr,
    input  logic [7:0] p_wdata,
    output logic       p_ack,
    output logic [7:0] p_rdata,
    output logic       sid_ceb,
    output logic       sid_rwb,
    output logic [5:0] sid_addr,
    output logic [7:0] sid_wdata,
    input  logic [7:0] sid_rdata,
`ifdef SID_ARB_FRAME_SYNC_EN
    input  logic       frame_tick,
    input  logic       p_eof,
`endif
    output logic       busy,
    output logic       gnt_id
);

    localparam int CNT_W = $clog2(max_int(STROBE_CYC, RECOVER_CYC) + 1);

    if (STROBE_CYC < MIN_STROBE || RECOVER_CYC < MIN_RECOVER) begin : g_bad_timing
        $error("sid_bus_arbiter: need STROBE_CYC >= %0d and RECOVER_CYC >= %0d",
               MIN_STROBE, MIN_RECOVER);
    end

    arb_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             acc_we;
    logic             p_elig;
    logic             gnt_vld;
    logic             gnt_sel;
    acc_req_t         h_bus;
    acc_req_t         p_bus;
    acc_req_t         sel_bus;

    assign h_bus   = '{we: h_we, addr: h_addr, wdata: h_wdata};
    assign p_bus   = '{we: p_we, addr: p_addr, wdata: p_wdata};
    assign sel_bus = (gnt_sel == PORT_PLAYER) ? p_bus : h_bus;
    assign busy    = (state != IDLE);

`ifdef SID_ARB_FRAME_SYNC_EN
    logic p_armed;
    logic eof_q;

    assign p_elig = p_req & p_armed;

    // Cleared on the same edge that raises p_ack, so the player cannot win
    // the IDLE cycle that follows its end-of-frame access.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_armed <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            if (state == IDLE && gnt_vld) begin
                eof_q <= (gnt_sel == PORT_PLAYER) & p_eof;
            end
            if (frame_tick) begin
                p_armed <= 1'b1;
            end else if (state == RECOVER && cnt == '0 && gnt_id == PORT_PLAYER && eof_q) begin
                p_armed <= 1'b0;
            end
        end
    end
`else
    assign p_elig = p_req;
`endif

    sid_arb_rr u_rr (
        .req     ({p_elig, h_req}),
        .last    (gnt_id),
        .gnt_vld (gnt_vld),
        .gnt_id  (gnt_sel)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            acc_we    <= 1'b0;
            sid_ceb   <= 1'b1;
            sid_rwb   <= 1'b1;
            sid_addr  <= '0;
            sid_wdata <= '0;
            h_ack     <= 1'b0;
            p_ack     <= 1'b0;
            h_rdata   <= '0;
            p_rdata   <= '0;
            gnt_id    <= PORT_PLAYER;
        end else begin
            h_ack <= 1'b0;
            p_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    // Address/data go out on the grant edge so they are stable
                    // for the whole SETUP cycle before CEb falls.
                    if (gnt_vld) begin
                        state     <= SETUP;
                        gnt_id    <= gnt_sel;
                        acc_we    <= sel_bus.we;
                        sid_addr  <= sel_bus.addr;
                        sid_wdata <= sel_bus.wdata;
                        sid_rwb   <= ~sel_bus.we;
                    end
                end
                SETUP: begin
                    state   <= STROBE;
                    sid_ceb <= 1'b0;
                    cnt     <= CNT_W'(STROBE_CYC - 1);
                end
                STROBE: begin
                    if (cnt == '0) begin
                        state   <= RECOVER;
                        sid_ceb <= 1'b1;
                        sid_rwb <= 1'b1;
                        cnt     <= CNT_W'(RECOVER_CYC - 1);
                        if (!acc_we) begin
                            if (gnt_id == PORT_PLAYER) p_rdata <= sid_rdata;
                            else                       h_rdata <= sid_rdata;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RECOVER: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        if (gnt_id == PORT_PLAYER) p_ack <= 1'b1;
                        else                       h_ack <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sid_bus_arbiter.sv
// Bench for sid_bus_arbiter with a behavioural SID register file on the bus.
// Latency: n/a.
// Backpressure: n/a.
module tb_sid_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       h_req = 1'b0, h_we = 1'b0;
    logic [5:0] h_addr = '0;
    logic [7:0] h_wdata = '0;
    logic       h_ack;
    logic [7:0] h_rdata;
    logic       p_req = 1'b0, p_we = 1'b0;
    logic [5:0] p_addr = '0;
    logic [7:0] p_wdata = '0;
    logic       p_ack;
    logic [7:0] p_rdata;
    logic       sid_ceb, sid_rwb;
    logic [5:0] sid_addr;
    logic [7:0] sid_wdata, sid_rdata;
    logic       busy, gnt_id;
`ifdef SID_ARB_FRAME_SYNC_EN
    logic       frame_tick = 1'b0;
    logic       p_eof = 1'b0;
`endif

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct packed {
        logic       port;
        logic       is_rd;
        logic [7:0] rdata;
    } exp_t;
    exp_t sb[$];

    // SID model: CEb/RWb registered, write on falling edge of the registered (RWb|CEb).
    logic [7:0] sid_regs [64] = '{default: 8'h00};
    logic       sid_ceb_q = 1'b1, sid_rwb_q = 1'b1;

    assign sid_rdata = sid_regs[sid_addr];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if ((sid_ceb_q | sid_rwb_q) && !(sid_ceb | sid_rwb)) sid_regs[sid_addr] <= sid_wdata;
        sid_ceb_q <= sid_ceb;
        sid_rwb_q <= sid_rwb;
    end

    sid_bus_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .h_req      (h_req),
        .h_we       (h_we),
        .h_addr     (h_addr),
        .h_wdata    (h_wdata),
        .h_ack      (h_ack),
        .h_rdata    (h_rdata),
        .p_req      (p_req),
        .p_we       (p_we),
        .p_addr     (p_addr),
        .p_wdata    (p_wdata),
        .p_ack      (p_ack),
        .p_rdata    (p_rdata),
        .sid_ceb    (sid_ceb),
        .sid_rwb    (sid_rwb),
        .sid_addr   (sid_addr),
        .sid_wdata  (sid_wdata),
        .sid_rdata  (sid_rdata),
`ifdef SID_ARB_FRAME_SYNC_EN
        .frame_tick (frame_tick),
        .p_eof      (p_eof),
`endif
        .busy       (busy),
        .gnt_id     (gnt_id)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one access and waits (bounded) for the first ack; reports what it saw.
    task automatic do_access(input logic port, input logic we, input logic [5:0] addr,
                             input logic [7:0] wd, output logic obs_port,
                             output logic [7:0] obs_rd, output int lat, output bit to);
        int t0;
        if (port == 1'b0) begin
            h_req = 1'b1; h_we = we; h_addr = addr; h_wdata = wd;
        end else begin
            p_req = 1'b1; p_we = we; p_addr = addr; p_wdata = wd;
        end
        t0 = cyc; to = 1'b1; lat = 0; obs_port = 1'b0; obs_rd = 8'h00;
        for (int i = 0; i < 20 && to; i++) begin
            tick();
            if (h_ack || p_ack) begin
                obs_port = p_ack;
                obs_rd   = p_ack ? p_rdata : h_rdata;
                lat      = cyc - t0;
                to       = 1'b0;
            end
        end
        if (port == 1'b0) h_req = 1'b0;
        else              p_req = 1'b0;
    endtask

    task automatic test_reset();
`ifdef SID_ARB_FRAME_SYNC_EN
        frame_tick = 1'b1;
`endif
        rst_n = 1'b0;
        tick(); tick();
        n_cmp++; if (sid_ceb !== 1'b1) begin n_fail++; $display("FAIL reset_ceb: got %b want 1", sid_ceb); end
        n_cmp++; if (sid_rwb !== 1'b1) begin n_fail++; $display("FAIL reset_rwb: got %b want 1", sid_rwb); end
        n_cmp++; if ({sid_addr, sid_wdata} !== 14'h0) begin n_fail++; $display("FAIL reset_addr_data: got %h/%h want 0/0", sid_addr, sid_wdata); end
        n_cmp++; if ({h_ack, p_ack} !== 2'b00) begin n_fail++; $display("FAIL reset_acks: got %b want 00", {h_ack, p_ack}); end
        n_cmp++; if ({h_rdata, p_rdata} !== 16'h0) begin n_fail++; $display("FAIL reset_rdata: got %h/%h want 0/0", h_rdata, p_rdata); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (gnt_id !== 1'b1) begin n_fail++; $display("FAIL reset_gnt_id: got %b want 1", gnt_id); end
        rst_n = 1'b1;
    endtask

    task automatic test_host_write();
        int t0, lat, ceb_low;
        bit got;
        exp_t e;
        sb.push_back('{port: 1'b0, is_rd: 1'b0, rdata: 8'h00});
        h_req = 1'b1; h_we = 1'b1; h_addr = 6'h04; h_wdata = 8'h41;
        t0 = cyc; got = 1'b0; ceb_low = 0; lat = 0;
        for (int i = 0; i < 12 && !got; i++) begin
            tick();
            if (!sid_ceb) ceb_low++;
            if (i == 0) begin
                n_cmp++; if (sid_addr !== 6'h04) begin n_fail++; $display("FAIL wr_setup_addr: got %h want 04", sid_addr); end
                n_cmp++; if (sid_wdata !== 8'h41) begin n_fail++; $display("FAIL wr_setup_wdata: got %h want 41", sid_wdata); end
                n_cmp++; if ({sid_ceb, sid_rwb, busy} !== 3'b101) begin n_fail++; $display("FAIL wr_setup_ctl: got ceb/rwb/busy %b want 101", {sid_ceb, sid_rwb, busy}); end
            end
            if (h_ack || p_ack) begin
                got = 1'b1; lat = cyc - t0; h_req = 1'b0;
                e = sb.pop_front();
                n_cmp++; if (p_ack !== e.port) begin n_fail++; $display("FAIL wr_ack_port: got %b want %b", p_ack, e.port); end
            end
        end
        n_cmp++; if (!got) begin n_fail++; $display("FAIL wr_ack_timeout: got no ack want ack"); end
        n_cmp++; if (lat != 5) begin n_fail++; $display("FAIL wr_latency: got %0d want 5", lat); end
        n_cmp++; if (ceb_low != 2) begin n_fail++; $display("FAIL wr_ceb_low: got %0d want 2", ceb_low); end
        n_cmp++; if (sid_regs[4] !== 8'h41) begin n_fail++; $display("FAIL wr_sid_reg4: got %h want 41", sid_regs[4]); end
        tick();
        n_cmp++; if ({h_ack, busy} !== 2'b00) begin n_fail++; $display("FAIL wr_ack_pulse: got ack/busy %b want 00", {h_ack, busy}); end
    endtask

    task automatic test_host_read();
        logic       op;
        logic [7:0] ord, p_prev;
        int         lat;
        bit         to;
        exp_t       e;
        sb.push_back('{port: 1'b0, is_rd: 1'b0, rdata: 8'h00});
        do_access(1'b0, 1'b1, 6'h25, 8'h99, op, ord, lat, to);
        e = sb.pop_front();
        n_cmp++; if (to || op !== e.port) begin n_fail++; $display("FAIL rd_prewrite: got to=%0d port=%b want ack on %b", to, op, e.port); end
        p_prev = p_rdata;
        sb.push_back('{port: 1'b0, is_rd: 1'b1, rdata: 8'h99});
        do_access(1'b0, 1'b0, 6'h25, 8'h00, op, ord, lat, to);
        e = sb.pop_front();
        n_cmp++; if (to || op !== e.port) begin n_fail++; $display("FAIL rd_ack: got to=%0d port=%b want ack on %b", to, op, e.port); end
        n_cmp++; if (ord !== e.rdata) begin n_fail++; $display("FAIL rd_h_rdata: got %h want %h", ord, e.rdata); end
        n_cmp++; if (lat != 5) begin n_fail++; $display("FAIL rd_latency: got %0d want 5", lat); end
        n_cmp++; if (p_rdata !== p_prev) begin n_fail++; $display("FAIL rd_p_rdata_kept: got %h want %h", p_rdata, p_prev); end
        // Player writes then reads a passthrough address; host rdata must hold.
        sb.push_back('{port: 1'b1, is_rd: 1'b0, rdata: 8'h00});
        do_access(1'b1, 1'b1, 6'h3A, 8'hC3, op, ord, lat, to);
        e = sb.pop_front();
        n_cmp++; if (to || op !== e.port) begin n_fail++; $display("FAIL rd_p_write: got to=%0d port=%b want ack on %b", to, op, e.port); end
        sb.push_back('{port: 1'b1, is_rd: 1'b1, rdata: 8'hC3});
        do_access(1'b1, 1'b0, 6'h3A, 8'h00, op, ord, lat, to);
        e = sb.pop_front();
        n_cmp++; if (to || op !== e.port || ord !== e.rdata) begin n_fail++; $display("FAIL rd_p_read: got to=%0d port=%b data=%h want port %b data %h", to, op, ord, e.port, e.rdata); end
        n_cmp++; if (h_rdata !== 8'h99) begin n_fail++; $display("FAIL rd_h_rdata_held: got %h want 99", h_rdata); end
    endtask

    task automatic test_round_robin();
        int   last_cyc, nacks;
        logic prev_port, obs;
        exp_t e;
        rst_n = 1'b0;
        tick(); tick();
        for (int i = 0; i < 6; i++) sb.push_back('{port: i[0], is_rd: 1'b0, rdata: 8'h00});
        h_req = 1'b1; h_we = 1'b1; h_addr = 6'h10; h_wdata = 8'hA0;
        p_req = 1'b1; p_we = 1'b1; p_addr = 6'h30; p_wdata = 8'h5B;
        rst_n = 1'b1;
        nacks = 0; last_cyc = 0; prev_port = 1'b0;
        for (int i = 0; i < 60 && nacks < 6; i++) begin
            tick();
            if (h_ack && p_ack) begin
                n_cmp++; n_fail++; $display("FAIL rr_dual_ack: got both acks want one");
                nacks = 6;
            end else if (h_ack || p_ack) begin
                obs = p_ack;
                e = sb.pop_front();
                n_cmp++; if (obs !== e.port) begin n_fail++; $display("FAIL rr_order[%0d]: got port %b want %b", nacks, obs, e.port); end
                if (nacks > 0) begin
                    n_cmp++; if (cyc - last_cyc != 5) begin n_fail++; $display("FAIL rr_spacing[%0d]: got %0d want 5", nacks, cyc - last_cyc); end
                    n_cmp++; if (obs === prev_port) begin n_fail++; $display("FAIL rr_repeat[%0d]: got port %b twice want alternation", nacks, obs); end
                end
                prev_port = obs; last_cyc = cyc; nacks++;
                if (nacks == 6) begin h_req = 1'b0; p_req = 1'b0; end
            end
        end
        h_req = 1'b0; p_req = 1'b0;
        n_cmp++; if (nacks != 6) begin n_fail++; $display("FAIL rr_ack_count: got %0d want 6", nacks); end
        sb.delete();
        tick();
    endtask

    task automatic test_reset_mid_strobe();
        int acks;
        h_req = 1'b1; h_we = 1'b1; h_addr = 6'h12; h_wdata = 8'h77;
        tick(); tick();
        n_cmp++; if (sid_ceb !== 1'b0) begin n_fail++; $display("FAIL rst_mid_in_strobe: got ceb %b want 0", sid_ceb); end
        rst_n = 1'b0; h_req = 1'b0;
        tick();
        n_cmp++; if ({sid_ceb, sid_rwb} !== 2'b11) begin n_fail++; $display("FAIL rst_mid_ceb_rwb: got %b want 11", {sid_ceb, sid_rwb}); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        rst_n = 1'b1; acks = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (h_ack || p_ack) acks++;
        end
        n_cmp++; if (acks != 0) begin n_fail++; $display("FAIL rst_mid_no_ack: got %0d acks want 0", acks); end
        n_cmp++; if (sid_regs[18] !== 8'h00 && sid_regs[18] !== 8'h77) begin n_fail++; $display("FAIL rst_mid_reg: got %h want 00 or 77", sid_regs[18]); end
    endtask

    task automatic test_pulse_drop();
        int   t0, lat, h_seen;
        bit   got;
        exp_t e;
        sb.push_back('{port: 1'b1, is_rd: 1'b0, rdata: 8'h00});
        p_req = 1'b1; p_we = 1'b1; p_addr = 6'h3F; p_wdata = 8'h5A;
        t0 = cyc; got = 1'b0; lat = 0; h_seen = 0;
        tick();
        p_req = 1'b0;
        tick();
        // Host pulses while the bus is busy: never reaches IDLE, so no cycle.
        h_req = 1'b1; h_we = 1'b1; h_addr = 6'h01; h_wdata = 8'hEE;
        tick();
        h_req = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (h_ack) h_seen++;
            if (p_ack && !got) begin
                got = 1'b1; lat = cyc - t0;
                e = sb.pop_front();
                n_cmp++; if (p_ack !== e.port) begin n_fail++; $display("FAIL pd_port: got %b want %b", p_ack, e.port); end
            end
        end
        n_cmp++; if (!got) begin n_fail++; $display("FAIL pd_ack: got no p_ack want p_ack"); end
        n_cmp++; if (lat != 5) begin n_fail++; $display("FAIL pd_latency: got %0d want 5", lat); end
        n_cmp++; if (h_seen != 0) begin n_fail++; $display("FAIL pd_host_dropped: got %0d h_ack want 0", h_seen); end
        n_cmp++; if (sid_regs[63] !== 8'h5A) begin n_fail++; $display("FAIL pd_reg63: got %h want 5a", sid_regs[63]); end
        n_cmp++; if (sid_regs[1] !== 8'h00) begin n_fail++; $display("FAIL pd_reg1: got %h want 00", sid_regs[1]); end
    endtask

`ifdef SID_ARB_FRAME_SYNC_EN
    task automatic test_frame_sync();
        int         acks, lat;
        logic       op;
        logic [7:0] ord;
        bit         to, got;
        exp_t       e;
        frame_tick = 1'b0;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        p_req = 1'b1; p_we = 1'b1; p_addr = 6'h08; p_wdata = 8'h01; acks = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (p_ack || busy) acks++;
        end
        n_cmp++; if (acks != 0) begin n_fail++; $display("FAIL fs_unarmed: got %0d active cycles want 0", acks); end
        p_req = 1'b0; frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        for (int k = 0; k < 3; k++) begin
            p_eof = (k == 2);
            sb.push_back('{port: 1'b1, is_rd: 1'b0, rdata: 8'h00});
            do_access(1'b1, 1'b1, 6'(8 + k), 8'(32 + k), op, ord, lat, to);
            e = sb.pop_front();
            n_cmp++; if (to || op !== e.port) begin n_fail++; $display("FAIL fs_write[%0d]: got to=%0d port=%b want ack on %b", k, to, op, e.port); end
        end
        p_eof = 1'b0; p_req = 1'b1; acks = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (p_ack || busy) acks++;
        end
        n_cmp++; if (acks != 0) begin n_fail++; $display("FAIL fs_blocked_after_eof: got %0d active cycles want 0", acks); end
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0; got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            tick();
            if (p_ack) begin got = 1'b1; p_req = 1'b0; end
        end
        p_req = 1'b0;
        n_cmp++; if (!got) begin n_fail++; $display("FAIL fs_rearmed: got no p_ack want p_ack"); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_host_write();
        test_host_read();
        test_round_robin();
        test_reset_mid_strobe();
        test_pulse_drop();
`ifdef SID_ARB_FRAME_SYNC_EN
        test_frame_sync();
`endif
        n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drained: got %0d left want 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
